uart_rx_monitor: RTL and testbench

//  Synthesizable 8N1 UART receiver, the receiving end of the therm tx link.

---
 rtl/uart_rx_monitor.sv | 114 +++++++++++
 tb/tb_uart_rx_monitor.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_monitor.sv
// 8N1 UART receiver: 2-FF synchronized input, mid-bit sampling, LSB first.
// Received bytes are held on rx_data/rx_valid until acknowledged with rd.
module uart_rx_monitor #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    input  logic       rd,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_TC = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_TC = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t          state;
    state_t          state_next;
    logic            rx_meta;
    logic            rx_s;
    logic            rx_p;
    logic [CW-1:0]   cnt;
    logic [2:0]      bit_idx;
    logic [7:0]      shift;
    logic            load_pending;
    logic            half_hit;
    logic            full_hit;
    logic            sample_data;
    logic            sample_stop;

    assign half_hit = (cnt == HALF_TC);
    assign full_hit = (cnt == FULL_TC);

    // Sync chain resets to the idle (high) line level so no false start edge appears
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
            rx_p    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
            rx_p    <= rx_s;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:  if (rx_p && !rx_s) state_next = START;
            START: if (half_hit) state_next = rx_s ? IDLE : DATA;
            DATA:  if (full_hit && (bit_idx == 3'd7)) state_next = STOP;
            STOP:  if (full_hit) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy        = (state != IDLE);
        sample_data = (state == DATA) && full_hit;
        sample_stop = (state == STOP) && full_hit;
    end

    // Counter restarts on every state change and after each data sample
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt     <= '0;
            bit_idx <= 3'd0;
            shift   <= 8'h00;
        end else begin
            if ((state_next != state) || sample_data) cnt <= '0;
            else if (state != IDLE)                   cnt <= cnt + CW'(1);

            if (state != DATA)    bit_idx <= 3'd0;
            else if (sample_data) bit_idx <= bit_idx + 3'd1;

            if (sample_data) shift[bit_idx] <= rx_s;
        end
    end

    // A byte load takes priority over rd; rd in the load cycle only clears the old overrun
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            load_pending <= 1'b0;
            frame_err    <= 1'b0;
            rx_data      <= 8'h00;
            rx_valid     <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            load_pending <= sample_stop && rx_s;
            frame_err    <= sample_stop && !rx_s;
            if (load_pending) begin
                rx_data  <= shift;
                rx_valid <= 1'b1;
                overrun  <= (rx_valid && !rd) || (overrun && !rd);
            end else if (rd) begin
                rx_valid <= 1'b0;
                overrun  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_monitor.sv
// Directed bench for uart_rx_monitor; a shortened bit period keeps frames short.
// A negedge monitor records valid rises, captured bytes and frame_err pulses.
module tb_uart_rx_monitor;

    localparam int BIT = 128;
    localparam int EXP_LAT = 2 + BIT / 2 + 9 * BIT + 1;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx;
    logic       rd;
    logic       rd_man;
    logic       rd_auto;
    logic       auto_en;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic       valid_prev = 1'b0;
    logic       fe_prev    = 1'b0;
    int         valid_rises = 0;
    int         fe_pulses   = 0;
    int         fe_long     = 0;
    int         ovr_seen    = 0;
    int         rise_cyc    = 0;
    int         t_start     = 0;
    logic [7:0] cap[$];

    assign rd = rd_man | rd_auto;

    uart_rx_monitor #(.CLKS_PER_BIT(BIT)) dut (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx),
        .rd        (rd),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .frame_err (frame_err),
        .overrun   (overrun),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst) begin
            valid_prev = 1'b0;
            fe_prev    = 1'b0;
            rd_auto    = 1'b0;
        end else begin
            if (rx_valid && !valid_prev) begin
                valid_rises++;
                rise_cyc = cyc;
                cap.push_back(rx_data);
            end
            if (frame_err) fe_pulses++;
            if (frame_err && fe_prev) fe_long++;
            if (overrun) ovr_seen++;
            rd_auto    = auto_en && rx_valid;
            valid_prev = rx_valid;
            fe_prev    = frame_err;
        end
    end

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] data, input logic stop_bit);
        rx = 1'b0;
        t_start = cyc;
        repeat (BIT) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = data[i];
            repeat (BIT) @(negedge clk);
        end
        rx = stop_bit;
        repeat (BIT) @(negedge clk);
        rx = 1'b1;
    endtask

    task automatic pulse_rd();
        @(negedge clk);
        rd_man = 1'b1;
        @(negedge clk);
        rd_man = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; rx = 1'b1; rd_man = 1'b0; auto_en = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        n_checks++; if (rx_data !== 8'h00) begin n_fail++; $display("[TB] FAIL reset_rx_data: got %h expected 00", rx_data); end
        n_checks++; if (rx_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_rx_valid: got %b expected 0", rx_valid); end
        n_checks++; if (frame_err !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_frame_err: got %b expected 0", frame_err); end
        n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_overrun: got %b expected 0", overrun); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
        @(negedge clk);
        rst = 1'b0;
        idle(8);
    endtask

    task automatic test_basic_byte();
        int vr0, fe0, lat;
        vr0 = valid_rises; fe0 = fe_pulses;
        send_frame(8'hA5, 1'b1);
        idle(4);
        #1;
        lat = rise_cyc - t_start;
        n_checks++; if (rx_data !== 8'hA5) begin n_fail++; $display("[TB] FAIL a5_data: got %h expected a5", rx_data); end
        n_checks++; if (rx_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL a5_valid: got %b expected 1", rx_valid); end
        n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("[TB] FAIL a5_overrun: got %b expected 0", overrun); end
        n_checks++; if (fe_pulses - fe0 !== 0) begin n_fail++; $display("[TB] FAIL a5_frame_err: got %0d pulses expected 0", fe_pulses - fe0); end
        n_checks++; if (valid_rises - vr0 !== 1) begin n_fail++; $display("[TB] FAIL a5_rises: got %0d expected 1", valid_rises - vr0); end
        n_checks++; if (lat < EXP_LAT - 1 || lat > EXP_LAT + 1) begin n_fail++; $display("[TB] FAIL a5_latency: got %0d expected %0d +/-1", lat, EXP_LAT); end
        idle(20);
        #1;
        n_checks++; if (rx_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL a5_valid_held: got %b expected 1", rx_valid); end
        pulse_rd();
        n_checks++; if (rx_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL a5_valid_after_rd: got %b expected 0", rx_valid); end
        pulse_rd();
        n_checks++; if (rx_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL rd_idle_valid: got %b expected 0", rx_valid); end
        n_checks++; if (rx_data !== 8'hA5) begin n_fail++; $display("[TB] FAIL rd_idle_data: got %h expected a5", rx_data); end
    endtask

    task automatic test_glitch();
        int vr0, fe0, busy_cnt;
        vr0 = valid_rises; fe0 = fe_pulses; busy_cnt = 0;
        @(negedge clk);
        for (int k = 0; k < 2 * BIT; k++) begin
            rx = (k < BIT / 8) ? 1'b0 : 1'b1;
            @(negedge clk);
            #1;
            if (busy) busy_cnt++;
        end
        n_checks++; if (busy_cnt < BIT / 2 - 1 || busy_cnt > BIT / 2 + 1) begin n_fail++; $display("[TB] FAIL glitch_busy_len: got %0d expected %0d +/-1", busy_cnt, BIT / 2); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL glitch_busy_end: got %b expected 0", busy); end
        n_checks++; if (valid_rises - vr0 !== 0) begin n_fail++; $display("[TB] FAIL glitch_valid: got %0d rises expected 0", valid_rises - vr0); end
        n_checks++; if (fe_pulses - fe0 !== 0) begin n_fail++; $display("[TB] FAIL glitch_frame_err: got %0d pulses expected 0", fe_pulses - fe0); end
    endtask

    task automatic test_frame_error();
        int vr0, fe0, fl0;
        vr0 = valid_rises; fe0 = fe_pulses; fl0 = fe_long;
        @(negedge clk);
        send_frame(8'h3C, 1'b0);
        idle(BIT);
        #1;
        n_checks++; if (fe_pulses - fe0 !== 1) begin n_fail++; $display("[TB] FAIL ferr_pulses: got %0d expected 1", fe_pulses - fe0); end
        n_checks++; if (fe_long - fl0 !== 0) begin n_fail++; $display("[TB] FAIL ferr_width: got %0d long cycles expected 0", fe_long - fl0); end
        n_checks++; if (rx_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL ferr_valid: got %b expected 0", rx_valid); end
        n_checks++; if (rx_data !== 8'hA5) begin n_fail++; $display("[TB] FAIL ferr_data: got %h expected a5", rx_data); end
        n_checks++; if (valid_rises - vr0 !== 0) begin n_fail++; $display("[TB] FAIL ferr_rises: got %0d expected 0", valid_rises - vr0); end
    endtask

    task automatic test_overrun();
        @(negedge clk);
        send_frame(8'h11, 1'b1);
        idle(4);
        #1;
        n_checks++; if (rx_data !== 8'h11) begin n_fail++; $display("[TB] FAIL ovr_first_data: got %h expected 11", rx_data); end
        n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("[TB] FAIL ovr_first_flag: got %b expected 0", overrun); end
        @(negedge clk);
        send_frame(8'h22, 1'b1);
        idle(4);
        #1;
        n_checks++; if (rx_data !== 8'h22) begin n_fail++; $display("[TB] FAIL ovr_second_data: got %h expected 22", rx_data); end
        n_checks++; if (rx_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL ovr_second_valid: got %b expected 1", rx_valid); end
        n_checks++; if (overrun !== 1'b1) begin n_fail++; $display("[TB] FAIL ovr_set: got %b expected 1", overrun); end
        pulse_rd();
        n_checks++; if (rx_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL ovr_rd_valid: got %b expected 0", rx_valid); end
        n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("[TB] FAIL ovr_rd_clear: got %b expected 0", overrun); end
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] d;
        int fe0;
        d = 8'h77;
        @(negedge clk);
        rx = 1'b0;
        repeat (BIT) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            rx = d[i];
            repeat (BIT) @(negedge clk);
        end
        rx = d[4];
        repeat (BIT / 2) @(negedge clk);
        #1;
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("[TB] FAIL midrst_busy_before: got %b expected 1", busy); end
        rst = 1'b1;
        #1;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL midrst_busy: got %b expected 0", busy); end
        n_checks++; if (rx_data !== 8'h00) begin n_fail++; $display("[TB] FAIL midrst_data: got %h expected 00", rx_data); end
        n_checks++; if (rx_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL midrst_valid: got %b expected 0", rx_valid); end
        n_checks++; if (overrun !== 1'b0 || frame_err !== 1'b0) begin n_fail++; $display("[TB] FAIL midrst_flags: got %b%b expected 00", overrun, frame_err); end
        rx = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        idle(8);
        fe0 = fe_pulses;
        send_frame(8'h81, 1'b1);
        idle(4);
        #1;
        n_checks++; if (rx_data !== 8'h81) begin n_fail++; $display("[TB] FAIL post_rst_data: got %h expected 81", rx_data); end
        n_checks++; if (rx_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL post_rst_valid: got %b expected 1", rx_valid); end
        n_checks++; if (fe_pulses - fe0 !== 0) begin n_fail++; $display("[TB] FAIL post_rst_ferr: got %0d expected 0", fe_pulses - fe0); end
        pulse_rd();
    endtask

    task automatic test_back_to_back();
        int vr0, fe0, ov0;
        vr0 = valid_rises; fe0 = fe_pulses; ov0 = ovr_seen;
        auto_en = 1'b1;
        @(negedge clk);
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        idle(BIT);
        #1;
        auto_en = 1'b0;
        n_checks++; if (valid_rises - vr0 !== 2) begin n_fail++; $display("[TB] FAIL b2b_rises: got %0d expected 2", valid_rises - vr0); end
        if (valid_rises - vr0 == 2) begin
            n_checks++; if (cap[vr0] !== 8'h00) begin n_fail++; $display("[TB] FAIL b2b_first: got %h expected 00", cap[vr0]); end
            n_checks++; if (cap[vr0 + 1] !== 8'hFF) begin n_fail++; $display("[TB] FAIL b2b_second: got %h expected ff", cap[vr0 + 1]); end
        end
        n_checks++; if (ovr_seen - ov0 !== 0) begin n_fail++; $display("[TB] FAIL b2b_overrun: got %0d cycles expected 0", ovr_seen - ov0); end
        n_checks++; if (fe_pulses - fe0 !== 0) begin n_fail++; $display("[TB] FAIL b2b_ferr: got %0d expected 0", fe_pulses - fe0); end
        n_checks++; if (rx_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL b2b_valid_acked: got %b expected 0", rx_valid); end
    endtask

    initial begin
        test_reset();
        test_basic_byte();
        test_glitch();
        test_frame_error();
        test_overrun();
        test_reset_mid_frame();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
